axil_apb_bridge_nx: RTL and testbench

AXIL_APB_BRIDGE_NX -- requirements
Module: axil_apb_bridge_nx

---
 rtl/axil_apb_pkg.sv | 24 ++
 rtl/axil_apb_decoder.sv | 42 ++++
 rtl/axil_apb_bridge_nx.sv | 254 +++++++++++++++++++++++++
 tb/tb_axil_apb_bridge_nx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB bridge.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package axil_apb_pkg;

  // Bridge sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // AXI response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Width of a completer index. A single completer still needs a 1-bit index.
  function automatic int idxWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axil_apb_decoder.sv
// Address decoder: maps an address onto one of NUM_SLV completer windows.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of addr.
// Ports: addr (in) -> sel (one-hot completer select), idx (binary index),
//        decerr (address lies outside every window; sel is all zero then).
module axil_apb_decoder
  import axil_apb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int NUM_SLV  = 4,
  parameter int REGION_W = 12
) (
  input  logic [ADDR_W-1:0]              addr,
  output logic [NUM_SLV-1:0]             sel,
  output logic [idxWidth(NUM_SLV)-1:0]   idx,
  output logic                           decerr
);

  localparam int IDX_W   = idxWidth(NUM_SLV);
  // Bits actually used to pick a completer; zero when there is only one.
  localparam int FIELD_W = $clog2(NUM_SLV);
  localparam logic [ADDR_W-1:0] FIELD_MASK = ADDR_W'((64'd1 << FIELD_W) - 64'd1);

  logic [ADDR_W-1:0] upper;
  logic [ADDR_W-1:0] field;

  assign upper = addr >> REGION_W;
  assign field = upper & FIELD_MASK;
  assign idx   = field[IDX_W-1:0];

  // Any set bit above the index field, or an index past the last completer
  // (non power-of-two NUM_SLV), is outside the mapped space.
  assign decerr = ((upper >> FIELD_W) != '0) || (field >= ADDR_W'(NUM_SLV));

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = !decerr && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/axil_apb_bridge_nx.sv
// AXI4-Lite subordinate to multi-completer APB requester bridge.
// Latency: AW+W capture to bvalid = 3 cycles with zero-wait APB; 1 cycle on decode error.
// Backpressure: one-entry AW/W/AR holding registers; ready drops while full, B/R held until bready/rready.
// Ports: clk/rst (sync, active high); AXI-Lite AW/W/B/AR/R channels;
//        APB request (paddr, psel one-hot, penable, pwrite, pwdata, pstrb, pprot);
//        APB completion per completer (prdata slots, pready, pslverr).
module axil_apb_bridge_nx
  import axil_apb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_SLV  = 4,
  parameter int REGION_W = 12,
  parameter int TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  // AW
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_W-1:0]         awaddr,
  input  logic [2:0]                awprot,
  // W
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  // B
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  // AR
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_W-1:0]         araddr,
  input  logic [2:0]                arprot,
  // R
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                rresp,
  // APB request
  output logic [ADDR_W-1:0]         paddr,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  output logic [2:0]                pprot,
  // APB completion
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idxWidth(NUM_SLV);
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  // Holding registers
  logic                awFull, wFull, arFull;
  logic [ADDR_W-1:0]   awAddrQ, arAddrQ;
  logic [2:0]          awProtQ, arProtQ;
  logic [DATA_W-1:0]   wDataQ;
  logic [STRB_W-1:0]   wStrbQ;

  // Sequencer state
  state_t              state;
  logic                prioWrite;   // 1: write wins the next tie
  logic                curWrite;
  logic [IDX_W-1:0]    curIdx;
  logic [CNT_W-1:0]    waitCnt;

  // Arbitration and decode of the candidate transaction
  logic                wrElig, pickWrite, startTx, issueWr, issueRd;
  logic [ADDR_W-1:0]   selAddr;
  logic [NUM_SLV-1:0]  decSel;
  logic [IDX_W-1:0]    decIdx;
  logic                decErr;

  // Completion signals of the completer currently addressed
  logic [DATA_W-1:0]   slotData;
  logic                slotReady, slotErr;

  assign awready = ~awFull;
  assign wready  = ~wFull;
  assign arready = ~arFull;

  assign wrElig    = awFull & wFull;
  assign pickWrite = wrElig & (prioWrite | ~arFull);
  assign startTx   = wrElig | arFull;
  assign issueWr   = (state == IDLE) && startTx && pickWrite;
  assign issueRd   = (state == IDLE) && startTx && !pickWrite;
  assign selAddr   = pickWrite ? awAddrQ : arAddrQ;

  axil_apb_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_SLV  (NUM_SLV),
    .REGION_W (REGION_W)
  ) u_decoder (
    .addr   (selAddr),
    .sel    (decSel),
    .idx    (decIdx),
    .decerr (decErr)
  );

  always_comb begin
    slotData  = '0;
    slotReady = 1'b0;
    slotErr   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (curIdx == IDX_W'(i)) begin
        slotData  = prdata[i*DATA_W +: DATA_W];
        slotReady = pready[i];
        slotErr   = pslverr[i];
      end
    end
  end

  // Holding registers free as soon as their transaction leaves IDLE, so the
  // next request can be captured while the APB phase is still running.
  always_ff @(posedge clk) begin
    if (rst) begin
      awFull <= 1'b0;
      wFull  <= 1'b0;
      arFull <= 1'b0;
    end else begin
      if (awvalid && !awFull) begin
        awFull  <= 1'b1;
        awAddrQ <= awaddr;
        awProtQ <= awprot;
      end else if (issueWr) begin
        awFull  <= 1'b0;
      end

      if (wvalid && !wFull) begin
        wFull  <= 1'b1;
        wDataQ <= wdata;
        wStrbQ <= wstrb;
      end else if (issueWr) begin
        wFull  <= 1'b0;
      end

      if (arvalid && !arFull) begin
        arFull  <= 1'b1;
        arAddrQ <= araddr;
        arProtQ <= arprot;
      end else if (issueRd) begin
        arFull  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prioWrite <= 1'b1;
      curWrite  <= 1'b0;
      curIdx    <= '0;
      waitCnt   <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
      bvalid    <= 1'b0;
      rvalid    <= 1'b0;
      bresp     <= OKAY;
      rresp     <= OKAY;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startTx) begin
            curWrite  <= pickWrite;
            prioWrite <= ~pickWrite;
            curIdx    <= decIdx;
            if (decErr) begin
              // Unmapped address: answer directly without touching APB
              state <= RESP;
              if (pickWrite) begin
                bvalid <= 1'b1;
                bresp  <= DECERR;
              end else begin
                rvalid <= 1'b1;
                rresp  <= DECERR;
                rdata  <= '0;
              end
            end else begin
              state   <= SETUP;
              psel    <= decSel;
              penable <= 1'b0;
              paddr   <= selAddr;
              pwrite  <= pickWrite;
              pprot   <= pickWrite ? awProtQ : arProtQ;
              pwdata  <= pickWrite ? wDataQ : '0;
              pstrb   <= pickWrite ? wStrbQ : '0;
            end
          end
        end

        SETUP: begin
          penable <= 1'b1;
          waitCnt <= '0;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (slotReady) begin
            psel    <= '0;
            penable <= 1'b0;
            state   <= RESP;
            if (curWrite) begin
              bvalid <= 1'b1;
              bresp  <= slotErr ? SLVERR : OKAY;
            end else begin
              rvalid <= 1'b1;
              rresp  <= slotErr ? SLVERR : OKAY;
              rdata  <= slotData;
            end
          end else if ((TIMEOUT > 0) && (waitCnt == CNT_W'(TIMEOUT - 1))) begin
            // Completer never answered: give up and report a slave error
            psel    <= '0;
            penable <= 1'b0;
            state   <= RESP;
            if (curWrite) begin
              bvalid <= 1'b1;
              bresp  <= SLVERR;
            end else begin
              rvalid <= 1'b1;
              rresp  <= SLVERR;
              rdata  <= '0;
            end
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end

        RESP: begin
          if ((curWrite && bready) || (!curWrite && rready)) begin
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_apb_bridge_nx.sv
// Directed bench for axil_apb_bridge_nx with an APB completer model and
// scoreboards for APB issue order and AXI responses.
`timescale 1ns/1ps
module tb_axil_apb_bridge_nx;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [AW-1:0]   awaddr, araddr, paddr;
  logic [2:0]      awprot, arprot, pprot;
  logic [DW-1:0]   wdata, rdata, pwdata;
  logic [3:0]      wstrb, pstrb;
  logic [1:0]      bresp, rresp;
  logic [NS-1:0]   psel, pready, pslverr;
  logic            penable, pwrite;
  logic [NS*DW-1:0] prdata;

  always #5 clk = ~clk;

  axil_apb_bridge_nx #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .REGION_W(12), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } apb_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  apb_t apbQ[$];
  rsp_t rspQ[$];
  int   nAssert = 0;
  int   nFail   = 0;

  // Completer model: fixed read data per slot, programmable wait states and error
  logic [31:0] slotDat [NS];
  int          waitCyc [NS];
  logic [NS-1:0] errEn;
  int          accCnt = 0;

  always_comb begin
    prdata  = '0;
    pready  = '0;
    pslverr = '0;
    for (int i = 0; i < NS; i++) begin
      prdata[i*DW +: DW] = slotDat[i];
      pready[i]  = psel[i] & penable & (accCnt >= waitCyc[i]);
      pslverr[i] = errEn[i] & pready[i];
    end
  end

  always @(posedge clk) begin
    if (penable && !(|pready)) accCnt <= accCnt + 1;
    else                       accCnt <= 0;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: APB issue scoreboard, protocol rules, AXI response scoreboard
  apb_t snap;
  apb_t expA;
  rsp_t expR;
  always @(negedge clk) begin
    if (!rst) begin
      if (|psel)   chk("psel_onehot", 128'($onehot(psel)), 128'd1);
      if (penable) chk("penable_needs_psel", 128'(|psel), 128'd1);
      if (|psel && !penable) begin
        chk("apb_expected", 128'(apbQ.size() != 0), 128'd1);
        if (apbQ.size() != 0) begin
          expA = apbQ.pop_front();
          chk("apb_setup", 128'({psel, paddr, pwrite, pwdata, pstrb, pprot}), 128'(expA));
        end
        snap = {psel, paddr, pwrite, pwdata, pstrb, pprot};
      end
      if (penable) chk("apb_stable", 128'({psel, paddr, pwrite, pwdata, pstrb, pprot}), 128'(snap));
      if ((bvalid && bready) || (rvalid && rready)) begin
        chk("rsp_expected", 128'(rspQ.size() != 0), 128'd1);
        if (rspQ.size() != 0) begin
          expR = rspQ.pop_front();
          chk("rsp_kind", 128'(bvalid), 128'(expR.wr));
          if (expR.wr) chk("bresp", 128'(bresp), 128'(expR.resp));
          else         chk("rresp_rdata", 128'({rresp, rdata}), 128'({expR.resp, expR.data}));
        end
      end
    end
  end

  task automatic pushW(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] resp);
    apbQ.push_back('{sel, a, 1'b1, d, s, 3'b010});
    rspQ.push_back('{1'b1, resp, 32'h0});
  endtask

  task automatic pushR(input logic [3:0] sel, input logic [31:0] a,
                       input logic [1:0] resp, input logic [31:0] d);
    apbQ.push_back('{sel, a, 1'b0, 32'h0, 4'h0, 3'b001});
    rspQ.push_back('{1'b0, resp, d});
  endtask

  // Drive any combination of AW/W/AR together until each has handshaken
  task automatic axiDrive(input bit doW, input logic [31:0] wa, input logic [31:0] d,
                          input logic [3:0] s, input bit doR, input logic [31:0] ra);
    int budget = 50;
    logic aok, wok, rok;
    awaddr = wa; awprot = 3'b010; wdata = d; wstrb = s;
    araddr = ra; arprot = 3'b001;
    awvalid = doW; wvalid = doW; arvalid = doR;
    while ((awvalid || wvalid || arvalid) && budget > 0) begin
      aok = awready; wok = wready; rok = arready;
      @(negedge clk);
      if (aok) awvalid = 1'b0;
      if (wok) wvalid  = 1'b0;
      if (rok) arvalid = 1'b0;
      budget--;
    end
    chk("axi_handshake_bound", 128'(budget > 0), 128'd1);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int budget = limit;
    while ((rspQ.size() != 0 || apbQ.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_bound", 128'(budget > 0), 128'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int budget;
    slotDat[0] = 32'h12345678; slotDat[1] = 32'h11110001;
    slotDat[2] = 32'h22220002; slotDat[3] = 32'h33330003;
    for (int i = 0; i < NS; i++) waitCyc[i] = 0;
    errEn = '0;
    rst = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; awprot = '0; wdata = '0; wstrb = '0; araddr = '0; arprot = '0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_readies", 128'({awready, wready, arready}), 128'b111);
    chk("reset_zero", 128'({bvalid, rvalid, psel, penable, pwrite, paddr, pwdata, pstrb,
                             pprot, bresp, rresp, rdata}), 128'd0);

    // Zero-wait write to completer 1, cycle-exact timing
    pushW(4'b0010, 32'h1008, 32'hDEADBEEF, 4'hF, 2'b00);
    awaddr = 32'h1008; awprot = 3'b010; awvalid = 1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("t1_e0", 128'({awready, wready, psel, bvalid}), 128'b0);
    @(negedge clk);
    chk("t1_e1_setup", 128'({awready, psel, penable}), 128'b1_0010_0);
    @(negedge clk);
    chk("t1_e2_access", 128'({psel, penable, bvalid}), 128'b0010_1_0);
    @(negedge clk);
    chk("t1_e3_bvalid", 128'({psel, penable, bvalid, bresp}), 128'b0000_0_1_00);
    waitDrain(20);

    // W ahead of AW, read captured while the write is on APB
    waitCyc[0] = 3;
    pushW(4'b0001, 32'h0010, 32'hCAFE0001, 4'h3, 2'b00);
    pushR(4'b0001, 32'h0004, 2'b00, 32'h12345678);
    wdata = 32'hCAFE0001; wstrb = 4'h3; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    chk("t2_w_held", 128'({wready, psel}), 128'b0);
    @(negedge clk);
    chk("t2_no_issue_wo_aw", 128'(psel), 128'd0);
    awaddr = 32'h0010; awprot = 3'b010; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    araddr = 32'h0004; arprot = 3'b001; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    chk("t2_read_captured_busy", 128'({arready, psel, pwrite}), 128'b0_0001_1);
    waitDrain(60);
    waitCyc[0] = 0;

    // Write and read pending together: alternating service
    for (int k = 0; k < 4; k++) begin
      pushW(4'b0010, 32'h1000 + 32'(k*4), 32'hA5000000 + 32'(k), 4'hF, 2'b00);
      pushR(4'b1000, 32'h3000 + 32'(k*4), 2'b00, 32'h33330003);
      axiDrive(1, 32'h1000 + 32'(k*4), 32'hA5000000 + 32'(k), 4'hF, 1, 32'h3000 + 32'(k*4));
      waitDrain(60);
    end

    // Empty strobe write still accesses APB; after a write a tie goes to the read
    pushW(4'b0010, 32'h1100, 32'h00000077, 4'h0, 2'b00);
    axiDrive(1, 32'h1100, 32'h00000077, 4'h0, 0, 32'h0);
    waitDrain(30);
    pushR(4'b0100, 32'h2008, 2'b00, 32'h22220002);
    pushW(4'b0001, 32'h0020, 32'h00000055, 4'hF, 2'b00);
    axiDrive(1, 32'h0020, 32'h00000055, 4'hF, 1, 32'h2008);
    waitDrain(60);

    // Decode errors
    rspQ.push_back('{1'b0, 2'b11, 32'h0});
    araddr = 32'h5000; arprot = 3'b001; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    chk("t4_e0_no_rvalid", 128'(rvalid), 128'd0);
    @(negedge clk);
    chk("t4_e1_decerr", 128'({rvalid, rresp, rdata, psel}), 128'({1'b1, 2'b11, 32'h0, 4'h0}));
    waitDrain(20);
    rspQ.push_back('{1'b1, 2'b11, 32'h0});
    axiDrive(1, 32'h80001000, 32'h1, 4'hF, 0, 32'h0);
    waitDrain(20);

    // Timeout on completer 2, then slave error on completer 3
    waitCyc[2] = 1000;
    pushW(4'b0100, 32'h2000, 32'h00000BAD, 4'hF, 2'b10);
    axiDrive(1, 32'h2000, 32'h00000BAD, 4'hF, 0, 32'h0);
    cnt = 0;
    budget = 60;
    while (!bvalid && budget > 0) begin
      if (penable) cnt++;
      @(negedge clk);
      budget--;
    end
    chk("timeout_penable_cycles", 128'(cnt), 128'd16);
    chk("timeout_psel_dropped", 128'({psel, penable}), 128'd0);
    waitDrain(20);
    waitCyc[2] = 0;
    errEn[3] = 1'b1;
    pushR(4'b1000, 32'h3010, 2'b10, 32'h33330003);
    axiDrive(0, 32'h0, 32'h0, 4'h0, 1, 32'h3010);
    waitDrain(30);
    errEn[3] = 1'b0;

    // Reset during ACCESS drops the transaction
    waitCyc[1] = 1000;
    bready = 0;
    apbQ.push_back('{4'b0010, 32'h1040, 1'b1, 32'h99, 4'hF, 3'b010});
    axiDrive(1, 32'h1040, 32'h99, 4'hF, 0, 32'h0);
    budget = 10;
    while (!penable && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("t6_reached_access", 128'(penable), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_reset_drops_apb", 128'({psel, penable, bvalid}), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready_after_release", 128'({awready, wready, arready, bvalid, rvalid}), 128'b11100);
    repeat (20) @(negedge clk);
    chk("t6_no_late_bvalid", 128'(bvalid), 128'd0);
    waitCyc[1] = 0;
    bready = 1;

    // Bridge usable after the mid-transaction reset
    pushW(4'b0001, 32'h0000, 32'h0F0F0F0F, 4'h5, 2'b00);
    axiDrive(1, 32'h0000, 32'h0F0F0F0F, 4'h5, 0, 32'h0);
    waitDrain(30);

    chk("apb_queue_empty", 128'(apbQ.size()), 128'd0);
    chk("rsp_queue_empty", 128'(rspQ.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
